// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
//   Control path for a subtractive GCD datapath. It loads operand A, then
//   operand B, from a shared data_in bus. It then repeatedly subtracts the
//   smaller register from the larger one until the comparator reports
//   equality. An iteration limit stops non-terminating inputs, such as a
//   zero operand, and reports them as an error.
//
// Parameters
//   ITER_W    width of the iteration counter
//   MAX_ITER  subtract cycles allowed before an error (< 2**ITER_W)
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request a new GCD (only honoured in IDLE)
//   lt, gt, eq       datapath comparator flags for Aout vs Bout
//   ldA, ldB         register load enables
//   sel1, sel2       subtractor minuend / subtrahend select (0=A, 1=B)
//   sel_load         bus select: 1=data_in, 0=subtractor output
//   req_a, req_b     upstream must present operand A / B on data_in now
//   busy             operation in progress
//   done             one-cycle pulse; result valid on Aout
//   err              one-cycle pulse alongside done; iteration limit hit
//   iter_count       subtract cycles in the current or last operation
// ---------------------------------------------------------------------------
module gcd_controller #(
  parameter int          ITER_W   = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              ldA,
  output logic              ldB,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_load,
  output logic              req_a,
  output logic              req_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] iter_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      iter_count <= '0;
    end else begin
      state      <= state_nxt;
      iter_count <= iter_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case
    // statement. A branch that forgets an assignment would otherwise infer
    // a latch.
    state_nxt = state;
    iter_nxt  = iter_count;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_load  = 1'b0;
    req_a     = 1'b0;
    req_b     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD_A;
          iter_nxt  = '0;
        end
      end

      S_LOAD_A: begin
        sel_load  = 1'b1;
        ldA       = 1'b1;
        req_a     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_LOAD_B;
      end

      S_LOAD_B: begin
        sel_load  = 1'b1;
        ldB       = 1'b1;
        req_b     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_CALC;
      end

      S_CALC: begin
        busy = 1'b1;
        // eq wins over everything, so malformed flag sets still terminate.
        // The limit check comes before any load, so the register contents
        // are frozen when the error is reported.
        if (eq) begin
          state_nxt = S_DONE;
        end else if (iter_count == ITER_LIMIT) begin
          state_nxt = S_ERR;
        end else if (gt) begin
          sel2     = 1'b1;          // A <= A - B
          ldA      = 1'b1;
          iter_nxt = iter_count + 1'b1;
        end else if (lt) begin
          sel1     = 1'b1;          // B <= B - A
          ldB      = 1'b1;
          iter_nxt = iter_count + 1'b1;
        end
        // No flag set: idle in CALC without loading or counting.
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// ---------------------------------------------------------------------------
// tb_gcd_controller
//   Drives two controllers, each with its own simple datapath:
//     u=0 : default parameters (MAX_ITER = 65535)
//     u=1 : MAX_ITER = 8, used to reach the error path quickly
//   Expected results come from a plain-arithmetic subtractive GCD model that
//   counts subtractions and gives up at the limit.
// ---------------------------------------------------------------------------
module tb_gcd_controller;

  logic        clk;
  logic        rst;
  logic        start_v  [2];
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic        ld_a     [2];
  logic        ld_b     [2];
  logic        s1       [2];
  logic        s2       [2];
  logic        sel_ld   [2];
  logic        rq_a     [2];
  logic        rq_b     [2];
  logic        busy_o   [2];
  logic        done_o   [2];
  logic        err_o    [2];
  logic [15:0] itc      [2];
  logic        f_lt     [2];
  logic        f_gt     [2];
  logic        f_eq     [2];
  logic [15:0] ra       [2];
  logic [15:0] rb       [2];
  logic [15:0] bus      [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  gcd_controller dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .lt(f_lt[0]), .gt(f_gt[0]), .eq(f_eq[0]),
    .ldA(ld_a[0]), .ldB(ld_b[0]), .sel1(s1[0]), .sel2(s2[0]),
    .sel_load(sel_ld[0]), .req_a(rq_a[0]), .req_b(rq_b[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .iter_count(itc[0])
  );

  gcd_controller #(.ITER_W(16), .MAX_ITER(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .lt(f_lt[1]), .gt(f_gt[1]), .eq(f_eq[1]),
    .ldA(ld_a[1]), .ldB(ld_b[1]), .sel1(s1[1]), .sel2(s2[1]),
    .sel_load(sel_ld[1]), .req_a(rq_a[1]), .req_b(rq_b[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .iter_count(itc[1])
  );

  // Datapath: two registers, a subtractor with operand muxes, and a bus mux.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus[i]  = sel_ld[i] ? (rq_a[i] ? op_a : op_b)
                          : ((s1[i] ? rb[i] : ra[i]) - (s2[i] ? rb[i] : ra[i]));
      f_lt[i] = ra[i] < rb[i];
      f_gt[i] = ra[i] > rb[i];
      f_eq[i] = ra[i] == rb[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld_a[i]) ra[i] <= bus[i];
      if (ld_b[i]) rb[i] <= bus[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: subtractive GCD with an iteration budget.
  function automatic void ref_gcd(input int a, input int b, input int max_it,
                                  output int res, output int n, output bit e);
    n = 0;
    e = 1'b0;
    while (a != b) begin
      if (n == max_it) begin
        e = 1'b1;
        break;
      end
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    res = a;
  endfunction

  // One full operation on instance u. pulse: spurious start during CALC.
  // hold: leave start asserted on return.
  task automatic run_op(input int u, input int a, input int b, input int max_it,
                        input bit pulse, input bit hold);
    int  exp_res, exp_n, cyc;
    bit  exp_e, got;
    ref_gcd(a, b, max_it, exp_res, exp_n, exp_e);
    op_a = 16'(a);
    op_b = 16'(b);
    @(posedge clk);
    @(negedge clk);
    start_v[u] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < exp_n + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && !hold) start_v[u] = 1'b0;
      if (pulse && cyc == 5) start_v[u] = 1'b1;
      if (pulse && cyc == 6) start_v[u] = 1'b0;
      check("ld_exclusive", 32'(ld_a[u] & ld_b[u]), 32'd0);
      if (cyc == 1) check("load_a_req", {rq_a[u], ld_a[u], sel_ld[u]}, 32'b111);
      if (cyc == 2) check("load_b_req", {rq_b[u], ld_b[u], sel_ld[u]}, 32'b111);
      if (done_o[u]) begin
        got = 1'b1;
        check("done_cycle", cyc, 32'(4 + exp_n));
        check("err",        32'(err_o[u]), 32'(exp_e));
        check("iter_count", 32'(itc[u]), 32'(exp_n));
        check("aout",       32'(ra[u]), 32'(exp_res));
        check("done_noload", {ld_a[u], ld_b[u], busy_o[u]}, 32'd0);
      end else begin
        check("busy", 32'(busy_o[u]), 32'd1);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a, b;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    op_a = '0;
    op_b = '0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_ctrl", {ld_a[u], ld_b[u], s1[u], s2[u], sel_ld[u],
                           rq_a[u], rq_b[u], busy_o[u], done_o[u], err_o[u]}, 32'd0);
      check("reset_iter", 32'(itc[u]), 32'd0);
    end
    rst = 1'b0;

    // Directed cases.
    run_op(0, 48, 18, 65535, 1'b0, 1'b0);
    run_op(0, 13, 13, 65535, 1'b0, 1'b0);
    run_op(1, 0, 5, 8, 1'b0, 1'b0);
    run_op(0, 48, 18, 65535, 1'b1, 1'b0);

    // start held high through DONE: IDLE for one cycle, then LOAD_A.
    run_op(0, 48, 18, 65535, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("hold_idle", {busy_o[0], rq_a[0], done_o[0]}, 32'd0);
    @(posedge clk); #1;
    check("hold_load_a", {rq_a[0], busy_o[0]}, 32'b11);
    start_v[0] = 1'b0;
    begin
      int k = 0;
      while (!done_o[0] && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      check("hold_done_seen", 32'(done_o[0]), 32'd1);
      check("hold_aout", 32'(ra[0]), 32'd6);
      check("hold_iter", 32'(itc[0]), 32'd4);
    end

    // Reset during CALC, then a fresh operation.
    @(posedge clk);
    @(negedge clk);
    op_a = 16'd48;
    op_b = 16'd18;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_iter", 32'(itc[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_ctrl", {ld_a[0], ld_b[0], s1[0], s2[0], sel_ld[0],
                             rq_a[0], rq_b[0], busy_o[0], done_o[0], err_o[0]}, 32'd0);
    check("mid_reset_iter", 32'(itc[0]), 32'd0);
    rst = 1'b0;
    run_op(0, 21, 14, 65535, 1'b0, 1'b0);

    // Randomized operands.
    for (int i = 0; i < 15; i++) begin
      a = int'($urandom_range(1, 255));
      b = int'($urandom_range(1, 255));
      run_op(0, a, b, 65535, 1'b0, 1'b0);
    end
    for (int i = 0; i < 15; i++) begin
      a = int'($urandom_range(0, 20));
      b = int'($urandom_range(0, 20));
      run_op(1, a, b, 8, 1'b0, 1'b0);
    end

    // Long run: 1 and 65535 take 65534 subtractions.
    run_op(0, 1, 65535, 65535, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
